// File: rtl/fb_arbiter.sv
// Framebuffer memory arbiter: fixed priority scan-out > draw > clear onto one registered single-port RAM command.
// Optional draw-stall statistics are built when FB_ARBITER_STATS_EN is defined.
module fb_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 8,
    parameter int FB_WORDS = 307200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_gnt,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              drw_req,
    input  logic              drw_we,
    input  logic [ADDR_W-1:0] drw_addr,
    input  logic [DATA_W-1:0] drw_wdata,
    output logic              drw_gnt,
    output logic              drw_rvalid,
    output logic [DATA_W-1:0] drw_rdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       drw_stall_cnt,
    output logic              clr_state
);

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } clr_state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WORDS - 1);

    clr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] color, color_nxt;

    logic              vid_win, drw_win, clr_win;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              drw_rd_pend;
    logic [DATA_W-1:0] vid_rdata_q, drw_rdata_q;

    // Handshake: a requester holds req (and its command) stable until it sees a one-cycle gnt;
    // a port whose gnt is high this cycle is not eligible, so a held req is never issued twice.
    always_comb begin
        vid_win   = vid_req && !vid_gnt;
        drw_win   = drw_req && !drw_gnt && !vid_win;
        clr_win   = (state == FILL) && !vid_win && !drw_win;

        state_nxt = state;
        cnt_nxt   = cnt;
        color_nxt = color;
        case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt = FILL;
                    cnt_nxt   = '0;
                    color_nxt = clr_color;
                end
            end
            FILL: begin
                if (clr_win) begin
                    cnt_nxt = cnt + ADDR_W'(1);
                    if (cnt == LAST_ADDR) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Reads leave mem_wdata untouched; idle cycles hold both address and data.
    always_comb begin
        cmd_we    = 1'b0;
        cmd_addr  = mem_addr;
        cmd_wdata = mem_wdata;
        if (vid_win) begin
            cmd_addr = vid_addr;
        end else if (drw_win) begin
            cmd_addr = drw_addr;
            cmd_we   = drw_we;
            if (drw_we) cmd_wdata = drw_wdata;
        end else if (clr_win) begin
            cmd_addr  = cnt;
            cmd_we    = 1'b1;
            cmd_wdata = color;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            color       <= '0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            vid_gnt     <= 1'b0;
            drw_gnt     <= 1'b0;
            drw_rd_pend <= 1'b0;
            vid_rvalid  <= 1'b0;
            drw_rvalid  <= 1'b0;
            vid_rdata_q <= '0;
            drw_rdata_q <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            color       <= color_nxt;
            mem_en      <= vid_win || drw_win || clr_win;
            mem_we      <= cmd_we;
            mem_addr    <= cmd_addr;
            mem_wdata   <= cmd_wdata;
            vid_gnt     <= vid_win;
            drw_gnt     <= drw_win;
            drw_rd_pend <= drw_win && !drw_we;
            vid_rvalid  <= vid_gnt;
            drw_rvalid  <= drw_rd_pend;
            if (vid_rvalid) vid_rdata_q <= mem_rdata;
            if (drw_rvalid) drw_rdata_q <= mem_rdata;
        end
    end

    // RAM data arrives in the strobe cycle itself, so it is passed straight through then held.
    assign vid_rdata = vid_rvalid ? mem_rdata : vid_rdata_q;
    assign drw_rdata = drw_rvalid ? mem_rdata : drw_rdata_q;
    assign clr_busy  = (state == FILL);
    assign clr_state = state;

`ifdef FB_ARBITER_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
        end else if (drw_req && !drw_gnt && vid_win && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign drw_stall_cnt = stall_q;
`else
    assign drw_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: directed scenarios plus random vid/draw traffic,
// checked by a queue scoreboard fed from a high-level memory reference model.
module tb_fb_arbiter;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 8;
    localparam int FB_WORDS = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              vid_req = 1'b0;
    logic [ADDR_W-1:0] vid_addr = '0;
    logic              vid_gnt, vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;
    logic              drw_req = 1'b0;
    logic              drw_we = 1'b0;
    logic [ADDR_W-1:0] drw_addr = '0;
    logic [DATA_W-1:0] drw_wdata = '0;
    logic              drw_gnt, drw_rvalid;
    logic [DATA_W-1:0] drw_rdata;
    logic              clr_start = 1'b0;
    logic [DATA_W-1:0] clr_color = '0;
    logic              clr_busy;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [15:0]       drw_stall_cnt;
    logic              clr_state;

    fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_WORDS(FB_WORDS)) dut (
        .clk(clk), .rst(rst),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .drw_req(drw_req), .drw_we(drw_we), .drw_addr(drw_addr), .drw_wdata(drw_wdata),
        .drw_gnt(drw_gnt), .drw_rvalid(drw_rvalid), .drw_rdata(drw_rdata),
        .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .drw_stall_cnt(drw_stall_cnt), .clr_state(clr_state)
    );

    // Clock and RAM model: unwritten words read back as addr[7:0]
    always #5 clk = ~clk;

    logic [DATA_W-1:0] ram[int];
    always @(posedge clk) begin
        if (mem_en && mem_we) ram[int'(mem_addr)] = mem_wdata;
        else if (mem_en) mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : mem_addr[7:0];
    end

    // Scoreboard state and reference model of memory contents
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0]        vid_exp_q[$];
    logic [DATA_W-1:0]        drw_exp_q[$];
    logic [ADDR_W+DATA_W-1:0] wr_exp_q[$];
    logic [DATA_W-1:0]        mem_ref[int];

    int busy_cycles = 0;
    int stolen = 0;
    int en_cnt = 0;
    logic prev_busy = 1'b0;
    logic prev_vid_gnt = 1'b0;
    logic prev_drw_gnt = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (mem_ref.exists(int'(a))) return mem_ref[int'(a)];
        return a[7:0];
    endfunction

    // Monitor: pops expectations whenever the DUT presents data or a write
    always @(negedge clk) begin
        if (rst) begin
            if (vid_rvalid) begin
                if (vid_exp_q.size() == 0) check("vid_rvalid_unexpected", 32'd1, 32'd0);
                else check("vid_rdata", 32'(vid_rdata), 32'(vid_exp_q.pop_front()));
            end
            if (drw_rvalid) begin
                if (drw_exp_q.size() == 0) check("drw_rvalid_unexpected", 32'd1, 32'd0);
                else check("drw_rdata", 32'(drw_rdata), 32'(drw_exp_q.pop_front()));
            end
            if (mem_en && mem_we) begin
                if (wr_exp_q.size() == 0) check("mem_write_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
                else check("mem_write", 32'({mem_addr, mem_wdata}), 32'(wr_exp_q.pop_front()));
            end
            check("vid_gnt_consecutive", 32'(vid_gnt && prev_vid_gnt), 32'd0);
            check("drw_gnt_consecutive", 32'(drw_gnt && prev_drw_gnt), 32'd0);
            check("two_grants", 32'(vid_gnt && drw_gnt), 32'd0);
            if (clr_busy) busy_cycles++;
            if (prev_busy && vid_gnt) stolen++;
            if (mem_en) en_cnt++;
        end
        prev_busy    = clr_busy;
        prev_vid_gnt = vid_gnt;
        prev_drw_gnt = drw_gnt;
    end

    // Driver tasks: all called and returning at #1 after a rising edge
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic vid_read(input logic [ADDR_W-1:0] a, output int lat);
        vid_addr = a;
        vid_req  = 1'b1;
        vid_exp_q.push_back(ref_rd(a));
        lat = 0;
        do begin
            idle(1);
            lat++;
        end while (!vid_gnt && lat < 50);
        check("vid_gnt_timeout", 32'(vid_gnt), 32'd1);
        vid_req = 1'b0;
    endtask

    task automatic drw_op(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        int lat = 0;
        drw_we    = we;
        drw_addr  = a;
        drw_wdata = d;
        drw_req   = 1'b1;
        if (we) begin
            wr_exp_q.push_back({a, d});
            mem_ref[int'(a)] = d;
        end else begin
            drw_exp_q.push_back(ref_rd(a));
        end
        do begin
            idle(1);
            lat++;
        end while (!drw_gnt && lat < 50);
        check("drw_gnt_timeout", 32'(drw_gnt), 32'd1);
        drw_req = 1'b0;
    endtask

    task automatic start_clear(input logic [DATA_W-1:0] c);
        for (int i = 0; i < FB_WORDS; i++) wr_exp_q.push_back({ADDR_W'(i), c});
        busy_cycles = 0;
        stolen      = 0;
        clr_color   = c;
        clr_start   = 1'b1;
        idle(1);
        clr_start   = 1'b0;
    endtask

    task automatic wait_clear_done(input logic [DATA_W-1:0] c);
        int n = 0;
        while (clr_busy && n < 300) begin
            idle(1);
            n++;
        end
        check("clr_done_timeout", 32'(clr_busy), 32'd0);
        for (int i = 0; i < FB_WORDS; i++) mem_ref[i] = c;
        idle(3);
        check("clr_writes_all_seen", 32'(wr_exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
        check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({tag, "_gnts"}, 32'({vid_gnt, drw_gnt}), 32'd0);
        check({tag, "_rvalids"}, 32'({vid_rvalid, drw_rvalid}), 32'd0);
        check({tag, "_rdatas"}, 32'({vid_rdata, drw_rdata}), 32'd0);
        check({tag, "_clr_busy"}, 32'({clr_busy, clr_state}), 32'd0);
        check({tag, "_stall_cnt"}, 32'(drw_stall_cnt), 32'd0);
    endtask

    initial begin
        int lat;
        int g;
        int n;
        int en_before;
        logic [15:0] exp_stall;

        // Reset held for 5 cycles
        idle(5);
        check_all_zero("reset");
        rst = 1'b1;
        idle(1);

        // Single scan-out read, unloaded latency and data path
        vid_read(ADDR_W'(32'h00010), lat);
        check("vid_latency", 32'(lat), 32'd1);
        idle(1);
        check("vid_rvalid_next", 32'(vid_rvalid), 32'd1);
        idle(2);

        // Simultaneous vid and draw read: vid first, draw exactly one cycle later
        vid_addr = ADDR_W'(32'h00030);
        drw_addr = ADDR_W'(32'h00020);
        drw_we   = 1'b0;
        vid_exp_q.push_back(ref_rd(vid_addr));
        drw_exp_q.push_back(ref_rd(drw_addr));
        vid_req = 1'b1;
        drw_req = 1'b1;
        idle(1);
        check("prio_vid_gnt", 32'({vid_gnt, drw_gnt}), 32'b10);
        vid_req = 1'b0;
        idle(1);
        check("prio_drw_gnt", 32'({vid_gnt, drw_gnt}), 32'b01);
        drw_req = 1'b0;
        idle(1);
`ifdef FB_ARBITER_STATS_EN
        exp_stall = 16'd1;
`else
        exp_stall = 16'd0;
`endif
        check("drw_stall_cnt", 32'(drw_stall_cnt), 32'(exp_stall));
        idle(3);

        // Held vid_req for 10 edges issues on alternate edges only
        vid_addr = ADDR_W'(32'h00044);
        for (int i = 0; i < 5; i++) vid_exp_q.push_back(ref_rd(vid_addr));
        vid_req = 1'b1;
        g = 0;
        repeat (10) begin
            idle(1);
            if (vid_gnt) g++;
        end
        vid_req = 1'b0;
        check("held_req_grants", 32'(g), 32'd5);
        idle(3);

        // Clear with no other traffic
        start_clear(8'h3C);
        wait_clear_done(8'h3C);
        check("clr_busy_cycles", 32'(busy_cycles), 32'(FB_WORDS));

        // Clear interleaved with vid reads, plus an ignored second clr_start
        start_clear(8'h3C);
        fork
            begin
                int l;
                for (int i = 0; i < 6; i++) begin
                    vid_read(ADDR_W'(32'h100 + i), l);
                    idle(2);
                end
            end
            begin
                idle(5);
                clr_color = 8'h55;
                clr_start = 1'b1;
                idle(1);
                clr_start = 1'b0;
            end
        join
        wait_clear_done(8'h3C);
        check("clr_stolen_nonzero", 32'(stolen > 0), 32'd1);
        check("clr_busy_delayed", 32'(busy_cycles), 32'(FB_WORDS + stolen));

        // Reset in the middle of a clear
        start_clear(8'hA7);
        n = 0;
        while (!(mem_en && mem_we && mem_addr == ADDR_W'(7)) && n < 100) begin
            idle(1);
            n++;
        end
        check("clr_reach_addr7", 32'(n < 100), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        wr_exp_q.delete();
        idle(3);
        rst = 1'b1;
        en_before = en_cnt;
        idle(20);
        check("no_mem_en_after_reset", 32'(en_cnt - en_before), 32'd0);
        check("clr_busy_after_reset", 32'(clr_busy), 32'd0);
        for (int i = 0; i < 7; i++) mem_ref[i] = 8'hA7;

        // Random concurrent scan-out and draw traffic
        fork
            begin
                int l;
                for (int i = 0; i < 30; i++) begin
                    vid_read(ADDR_W'($urandom_range(32'h100, 32'h1FF)), l);
                    idle($urandom_range(0, 3));
                end
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    drw_op(1'($urandom_range(0, 1)), ADDR_W'(32'h200 + $urandom_range(0, 15)),
                           DATA_W'($urandom_range(0, 255)));
                    idle($urandom_range(0, 3));
                end
            end
        join
        for (int i = 0; i < 8; i++) begin
            vid_read(ADDR_W'(i), lat);
            idle($urandom_range(0, 2));
        end
        idle(5);

        check("vid_queue_empty", 32'(vid_exp_q.size()), 32'd0);
        check("drw_queue_empty", 32'(drw_exp_q.size()), 32'd0);
        check("wr_queue_empty", 32'(wr_exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 19, framebuffer word-address width; DATA_W, 8, pixel width; FB_WORDS, 307200, words filled by a clear operation (640x480).
REQ-002 clk  in  1  single system clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 vid_req  in  1  scan-out read request, held until vid_gnt.
REQ-005 vid_addr  in  ADDR_W  scan-out read address, stable while vid_req high.
REQ-006 vid_gnt  out  1  one-cycle pulse, the vid read was issued to memory.
REQ-007 vid_rvalid / vid_rdata  out  1 / DATA_W  read-data strobe and data.
REQ-008 drw_req, drw_we, drw_addr, drw_wdata  in  1, 1, ADDR_W, DATA_W  draw-engine access request, held stable until drw_gnt.
REQ-009 drw_gnt  out  1  one-cycle pulse, draw access issued.
REQ-010 drw_rvalid / drw_rdata  out  1 / DATA_W  draw read-data strobe and data (reads only).
REQ-011 clr_start  in  1  pulse, begin filling framebuffer with clr_color.
REQ-012 clr_color  in  DATA_W  fill value, captured on accepted clr_start.
REQ-013 clr_busy  out  1  high while a clear is in progress.
REQ-014 mem_en, mem_we, mem_addr, mem_wdata  out  1, 1, ADDR_W, DATA_W  single-port RAM command, registered.
REQ-015 mem_rdata  in  DATA_W  RAM read data, valid one cycle after mem_en with mem_we low.
REQ-016 drw_stall_cnt  out  16  draw-stall counter (see Configuration).

Function
REQ-017 Arbitration evaluated every rising edge; fixed priority vid > drw > clr; at most one memory command per cycle.
REQ-018 A port is eligible when its req is high and its gnt is not currently high (prevents double issue of a held request); same-port issue rate is therefore at most one per 2 cycles.
REQ-019 Winner's command appears on mem_* and its gnt pulses high in the cycle after the sampling edge (request-to-grant latency 1 cycle minimum).
REQ-020 Read data is routed by a registered one-cycle tag: vid_rvalid or drw_rvalid pulses exactly one cycle after the corresponding gnt, with *_rdata = mem_rdata; *_rdata holds last value otherwise.
REQ-021 Draw writes produce drw_gnt only, never drw_rvalid.
REQ-022 Clear FSM states: IDLE, FILL. IDLE->FILL on clr_start (captures clr_color, address counter = 0, clr_busy = 1); clr_start while FILL is ignored.
REQ-023 In FILL, each cycle with no vid/drw issue writes clr_color to counter address and increments counter; after writing FB_WORDS-1, FSM returns to IDLE and clr_busy falls the following cycle.
REQ-024 Counter does not advance in cycles lost to vid or drw; no address is skipped or written twice.
REQ-025 Draw writes during FILL are not overwritten only if their address was already cleared; ordering beyond this is not guaranteed.
REQ-026 When idle (no winner), mem_en = 0 and mem_we = 0; mem_addr/mem_wdata hold.

Reset
REQ-027 While rst low: mem_en, mem_we, all gnt, all rvalid, clr_busy = 0; mem_addr, mem_wdata, *_rdata, clear counter, drw_stall_cnt = 0; clear FSM = IDLE.
REQ-028 Reset asserted mid-clear aborts the clear; no further writes after release until a new clr_start.
REQ-029 First arbitration occurs on the first rising edge after rst rises.

Configuration
REQ-030 Macro FB_ARBITER_STATS_EN defined: drw_stall_cnt increments (saturating at 16'hFFFF) each cycle drw_req is high and the draw port is eligible but loses to vid.
REQ-031 Macro not defined: drw_stall_cnt is tied to 0 and no counter logic is built; all other behaviour identical.

Verification
REQ-032 Reset 5 cycles, release, single vid_req addr 0x00010 with mem_rdata model = addr[7:0] -> vid_gnt 1 cycle after request, vid_rvalid next cycle, vid_rdata = 0x10.
REQ-033 vid_req and drw_req (read, addr 0x00020) raised same cycle -> vid_gnt first; drw_gnt exactly one cycle later; drw_rvalid with data 0x20; with STATS_EN drw_stall_cnt = 1.
REQ-034 vid_req held continuously with requester dropping req after each gnt and re-raising next cycle -> no double-issue, vid_gnt never on consecutive cycles.
REQ-035 clr_start, clr_color 0x3C, FB_WORDS overridden to 16, no other traffic -> 16 consecutive writes addr 0..15 data 0x3C, clr_busy high 16 cycles then low.
REQ-036 Same clear with vid_req every 4th cycle -> every address 0..15 written exactly once, completion delayed by number of vid grants; second clr_start mid-fill ignored.
REQ-037 rst pulled low at clear address 7 -> all outputs zero asynchronously; after release no mem_en until new request.
